// File: rtl/sha3_pkg.sv
// Shared types, rate table and domain byte for the SHA-3 stream padder.
// Build macro SHA3_PAD_LEGACY_KECCAK_EN selects the original Keccak domain byte 0x01 instead of 0x06.
package sha3_pkg;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    localparam int RATE_BITS [4] = '{1152, 1088, 832, 576};

`ifdef SHA3_PAD_LEGACY_KECCAK_EN
    localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif

    // Words per rate block; every legal data width divides every rate exactly.
    function automatic int wpb(input mode_t mode, input int dw);
        return RATE_BITS[mode] / dw;
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Builds one padded word: keeps the first k bytes, optionally drops the domain byte at byte k,
// and ORs the closing 0x80 into the top byte when the word ends a rate block.
module sha3_pad_word
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KW         = $clog2(DATA_WIDTH / 8 + 1)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [KW-1:0]         keepCnt_i,
    input  logic                  insertPad_i,
    input  logic                  lastInBlock_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int NB = DATA_WIDTH / 8;

    always_comb begin
        word_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(keepCnt_i)) begin
                word_o[8*i +: 8] = data_i[8*i +: 8];
            end else if (insertPad_i && (i == int'(keepCnt_i))) begin
                word_o[8*i +: 8] = PAD_DOMAIN;
            end
        end
        // Domain byte and closing bit may share the top byte (0x86 / 0x81).
        if (lastInBlock_i) begin
            word_o[DATA_WIDTH-1 -: 8] = word_o[DATA_WIDTH-1 -: 8] | 8'h80;
        end
    end

endmodule

// File: rtl/sha3_axis_padder.sv
// SHA-3 multi-rate padder: byte AXI-Stream message in, indexed rate-block words out with final-block flag.
// Domain byte chosen in sha3_pkg by build macro SHA3_PAD_LEGACY_KECCAK_EN (default FIPS 202, 0x06).
module sha3_axis_padder
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    input  logic [1:0]              s_tuser,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [7:0]              m_tdest,
    output logic                    m_tlast,
    output logic [1:0]              m_tuser,
    output logic                    m_tid
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int KW = $clog2(NB + 1);
    localparam logic [KW-1:0] FULL_K = KW'(NB);

    state_t                  state_q;
    logic [7:0]              cnt_q;
    mode_t                   mode_q;
    logic                    padPlaced_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic                    m_tvalid_q;
    logic [7:0]              m_tdest_q;
    logic                    m_tlast_q;
    logic [1:0]              m_tuser_q;
    logic                    m_tid_q;

    logic                    canLoad;
    logic                    beatFire;
    mode_t                   curMode;
    logic [7:0]              lastIdx;
    logic                    atLast;
    logic [KW-1:0]           keepCnt;
    logic                    partialLast;
    logic [DATA_WIDTH-1:0]   padData;
    logic [KW-1:0]           padK;
    logic                    padInsert;
    logic                    padLast;
    logic [DATA_WIDTH-1:0]   padWord;

    assign canLoad  = !m_tvalid_q || m_tready;
    assign s_tready = ARESETn && ((state_q == S_IDLE) || (state_q == S_MSG)) && canLoad;
    assign beatFire = s_tvalid && s_tready;

    // The first beat of a message uses the live mode; later beats use the latched one.
    assign curMode = (state_q == S_IDLE) ? mode_t'(s_tuser) : mode_q;
    assign lastIdx = 8'(wpb(curMode, DATA_WIDTH) - 1);
    assign atLast  = (cnt_q == lastIdx);

    always_comb begin
        keepCnt = '0;
        for (int i = 0; i < NB; i++) begin
            keepCnt = keepCnt + KW'(s_tkeep[i]);
        end
    end

    assign partialLast = s_tlast && (keepCnt < FULL_K);

    always_comb begin
        padData   = s_tdata;
        padK      = FULL_K;
        padInsert = 1'b0;
        padLast   = 1'b0;
        if (state_q == S_PAD) begin
            padData   = '0;
            padK      = '0;
            padInsert = !padPlaced_q;
            padLast   = atLast;
        end else if (s_tlast) begin
            padK      = keepCnt;
            padInsert = 1'b1;
            padLast   = atLast && partialLast;
        end
    end

    sha3_pad_word #(
        .DATA_WIDTH (DATA_WIDTH),
        .KW         (KW)
    ) u_pad_word (
        .data_i        (padData),
        .keepCnt_i     (padK),
        .insertPad_i   (padInsert),
        .lastInBlock_i (padLast),
        .word_o        (padWord)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mode_q      <= SHA3_224;
            padPlaced_q <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tdest_q   <= 8'd0;
            m_tlast_q   <= 1'b0;
            m_tuser_q   <= 2'd0;
            m_tid_q     <= 1'b0;
        end else begin
            if (m_tvalid_q && m_tready) begin
                m_tvalid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE, S_MSG: begin
                    if (beatFire) begin
                        if (state_q == S_IDLE) begin
                            mode_q <= curMode;
                        end
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= padWord;
                        m_tdest_q  <= cnt_q;
                        m_tlast_q  <= atLast;
                        m_tuser_q  <= curMode;
                        if (!s_tlast) begin
                            m_tid_q <= 1'b0;
                            cnt_q   <= atLast ? 8'd0 : cnt_q + 8'd1;
                            state_q <= S_MSG;
                        end else if (partialLast) begin
                            m_tid_q     <= 1'b1;
                            padPlaced_q <= 1'b1;
                            cnt_q       <= atLast ? 8'd0 : cnt_q + 8'd1;
                            state_q     <= atLast ? S_IDLE : S_PAD;
                        end else begin
                            // Full last word: padding spills over, possibly into a whole new block.
                            m_tid_q     <= !atLast;
                            padPlaced_q <= 1'b0;
                            cnt_q       <= atLast ? 8'd0 : cnt_q + 8'd1;
                            state_q     <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (canLoad) begin
                        m_tvalid_q  <= 1'b1;
                        m_tdata_q   <= padWord;
                        m_tdest_q   <= cnt_q;
                        m_tlast_q   <= atLast;
                        m_tuser_q   <= mode_q;
                        m_tid_q     <= 1'b1;
                        padPlaced_q <= 1'b1;
                        cnt_q       <= atLast ? 8'd0 : cnt_q + 8'd1;
                        state_q     <= atLast ? S_IDLE : S_PAD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tdest  = m_tdest_q;
    assign m_tlast  = m_tlast_q;
    assign m_tuser  = m_tuser_q;
    assign m_tid    = m_tid_q;

endmodule
